// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, FSM states and the status flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per enabled clock.
// Bit 0 is folded in on the start edge, so WIDTH enabled edges (start included) finish the job.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               last;

  // Final iteration happens on this edge.
  assign last = busy_q && en && (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state of the shift-add datapath; everything freezes while en is low.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = b >> 1;
      cnt_d    = CNT_W'(1);
      busy_d   = 1'b1;
    end else if (busy_q && en) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      busy_d   = !last;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = last;
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, status flags and an iterative multiplier.
// Optional build macro ALU_PIPE_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  flags_t             flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  op_e                op;
  logic               out_free, accept, load_single, load_mul;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum, diff, shl_w, shr_w;
  logic [CNT_W-1:0]   amt;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c, sc_v;

  assign op          = op_e'(operation);
  assign out_free    = !out_valid_q || out_ready;
  assign in_ready    = rst_n && en && (state_q == IDLE) && !mul_busy && out_free;
  assign accept      = in_valid && in_ready;
  assign load_single = accept && (op != OP_MUL);
  assign load_mul    = en && (state_q == MUL_DONE) && out_free;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && (op == OP_MUL)),
    .en     (en),
    .a      (a),
    .b      (b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  // Single-cycle result and carry/overflow. Shifts use one spare bit to catch the bit shifted
  // out; amounts beyond WIDTH naturally shift everything (including that bit) away.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    amt    = b[CNT_W-1:0];
    shl_w  = {1'b0, a} << amt;
    shr_w  = {a, 1'b0} >> amt;
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    unique case (op)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = !diff[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_SHL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_w[WIDTH:1];
        sc_c   = shr_w[0];
      end
      OP_MUL: sc_res = '0;
    endcase
`ifdef ALU_PIPE_SAT_EN
    // Overflow direction follows the sign of a for both ADD and SUB.
    if (((op == OP_ADD) || (op == OP_SUB)) && sc_v) begin
      sc_res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // FSM next state: IDLE -> MUL_RUN -> MUL_DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept && (op == OP_MUL)) state_d = MUL_RUN;
      MUL_RUN:  if (mul_done) state_d = MUL_DONE;
      MUL_DONE: if (load_mul) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output register next state: load a new result, or retire the current one on handshake.
  always_comb begin
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (load_single) begin
      alu_out_d   = sc_res;
      flags_d.z   = (sc_res == '0);
      flags_d.c   = sc_c;
      flags_d.v   = sc_v;
      flags_d.n   = sc_res[WIDTH-1];
      out_valid_d = 1'b1;
    end else if (load_mul) begin
      alu_out_d   = mul_product[WIDTH-1:0];
      flags_d.z   = (mul_product[WIDTH-1:0] == '0);
      flags_d.c   = |mul_product[2*WIDTH-1:WIDTH];
      flags_d.v   = 1'b0;
      flags_d.n   = mul_product[WIDTH-1];
      out_valid_d = 1'b1;
    end else if (en && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_out_q   <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign flag_z    = flags_q.z;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign flag_n    = flags_q.n;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): table-driven vectors through a scoreboard,
// plus hand-written multiply latency, stall, back-pressure and reset sequences.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n, en, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, alu_out;
  logic [2:0] operation;
  logic       flag_z, flag_c, flag_v, flag_n;

  int checks = 0;
  int errors = 0;

  // Expected results: {alu_out, z, c, v, n}.
  logic [11:0] exp_q[$];

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic [3:0] fl;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  alu_pipe #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .operation(operation),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .flag_n   (flag_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb,
                              input logic [7:0] o, input logic [3:0] f);
    vec_t v;
    v.op = op; v.a = aa; v.b = bb; v.out = o; v.fl = f;
    return v;
  endfunction

  // Scoreboard consumer: compare each result as it is handed off downstream.
  always @(negedge clk) begin
    logic [11:0] e;
    if (rst_n && en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h, required no output", alu_out);
      end else begin
        e = exp_q.pop_front();
        chk("result", {24'd0, alu_out}, {24'd0, e[11:4]});
        chk("flags", {28'd0, flag_z, flag_c, flag_v, flag_n}, {28'd0, e[3:0]});
      end
    end
  end

  // Offer one op; push its expectation on the cycle it is accepted. Called at posedge+1.
  task automatic send(input vec_t v);
    int n = 0;
    operation = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back({v.out, v.fl});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // MUL with optional en stall window (in cycles after accept) and an optional second op
  // offered while busy. Latency = accept edge to the edge that raises out_valid.
  task automatic run_mul(input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] o,
                         input logic [3:0] f, input int stall_at, input int stall_len,
                         input int exp_lat, input bit offer);
    int lat = 0;
    int rdy = 0;
    operation = 3'b111; a = aa; b = bb; in_valid = 1'b1;
    @(negedge clk);
    chk("mul_start_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back({o, f});
    @(posedge clk);
    #1;
    if (offer) begin
      operation = 3'b000; a = 8'h01; b = 8'h01;
    end else begin
      in_valid = 1'b0;
    end
    while (lat < 60) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) rdy++;
      @(posedge clk);
      lat++;
      #1 en = !((lat >= stall_at) && (lat < stall_at + stall_len));
    end
    en = 1'b1;
    chk("mul_latency", lat, exp_lat);
    chk("mul_busy_in_ready", rdy, 0);
    if (offer) begin
      chk("offer_accept", {31'd0, in_ready}, 32'd1);
      if (in_ready) exp_q.push_back({8'h02, 4'b0000});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    int spurious;
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; operation = '0;

    // flags column: {z, c, v, n}
    vecs[0]  = mk(3'b000, 8'h12, 8'h23, 8'h35, 4'b0000);
    vecs[1]  = mk(3'b001, 8'h34, 8'h23, 8'h11, 4'b0100);
`ifdef ALU_PIPE_SAT_EN
    vecs[2]  = mk(3'b000, 8'h7F, 8'h01, 8'h7F, 4'b0010);
`else
    vecs[2]  = mk(3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011);
`endif
    vecs[3]  = mk(3'b010, 8'hF0, 8'h0F, 8'h00, 4'b1000);
    vecs[4]  = mk(3'b011, 8'hF0, 8'h0F, 8'hFF, 4'b0001);
    vecs[5]  = mk(3'b100, 8'hAA, 8'hFF, 8'h55, 4'b0000);
    vecs[6]  = mk(3'b101, 8'h81, 8'h01, 8'h02, 4'b0100);
    vecs[7]  = mk(3'b110, 8'h81, 8'h09, 8'h00, 4'b1000);
    vecs[8]  = mk(3'b101, 8'h81, 8'h08, 8'h00, 4'b1100);
    vecs[9]  = mk(3'b110, 8'h81, 8'h08, 8'h00, 4'b1100);
    vecs[10] = mk(3'b110, 8'h81, 8'h01, 8'h40, 4'b0100);
    vecs[11] = mk(3'b001, 8'h10, 8'h20, 8'hF0, 4'b0001);
    vecs[12] = mk(3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100);
`ifdef ALU_PIPE_SAT_EN
    vecs[13] = mk(3'b001, 8'h80, 8'h01, 8'h80, 4'b0111);
    vecs[19] = mk(3'b000, 8'h80, 8'h80, 8'h80, 4'b0111);
`else
    vecs[13] = mk(3'b001, 8'h80, 8'h01, 8'h7F, 4'b0110);
    vecs[19] = mk(3'b000, 8'h80, 8'h80, 8'h00, 4'b1110);
`endif
    vecs[14] = mk(3'b111, 8'h12, 8'h23, 8'h76, 4'b0100);
    vecs[15] = mk(3'b111, 8'h0F, 8'h11, 8'hFF, 4'b0001);
    vecs[16] = mk(3'b111, 8'hFF, 8'hFF, 8'h01, 4'b0100);
    vecs[17] = mk(3'b111, 8'h00, 8'hAB, 8'h00, 4'b1000);
    vecs[18] = mk(3'b101, 8'h81, 8'h00, 8'h81, 4'b0001);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_out", {24'd0, alu_out}, 32'd0);
    chk("rst_flags", {28'd0, flag_z, flag_c, flag_v, flag_n}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table vectors, back to back
    for (int i = 0; i < NV; i++) send(vecs[i]);
    drain();

    // MUL latency with a second operand offered while busy
    run_mul(8'h12, 8'h23, 8'h76, 4'b0100, 0, 0, 8, 1'b1);
    drain();

    // Back-pressure: result held, upstream stalled, released handshake accepts next op
    out_ready = 1'b0;
    send(mk(3'b000, 8'h05, 8'h03, 8'h08, 4'b0000));
    operation = 3'b001; a = 8'h09; b = 8'h04; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_alu_out", {24'd0, alu_out}, 32'h08);
      chk("bp_flags", {28'd0, flag_z, flag_c, flag_v, flag_n}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back({8'h05, 4'b0100});
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // en low for 3 cycles mid-multiply
    run_mul(8'h0F, 8'h11, 8'hFF, 4'b0001, 3, 3, 11, 1'b0);
    drain();

    // Reset mid-multiply: no result may appear
    operation = 3'b111; a = 8'h12; b = 8'h23; in_valid = 1'b1;
    @(negedge clk);
    chk("rst_mul_start_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_alu_out", {24'd0, alu_out}, 32'd0);
    chk("midrst_flags", {28'd0, flag_z, flag_c, flag_v, flag_n}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    chk("midrst_no_result", spurious, 0);
    chk("midrst_alu_out_after", {24'd0, alu_out}, 32'd0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Adds:
  - a WIDTH parameter
  - valid/ready handshakes on the input and output sides
  - status flags
  - an iterative shift-add multiplier
- Sits between the operand-fetch and writeback stages of the datapath.
- Holds one operation in flight; stalls upstream while busy or back-pressured.

Parameters:
- WIDTH, 8, operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable. When 0: no accept, multiplier frozen, output register holds.
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block can accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- operation  in  3  opcode (alu_pkg::op_e)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- alu_out  out  WIDTH  result
- flag_z  out  1  result == 0
- flag_c  out  1  carry / no-borrow / shifted-out bit / multiply high-half nonzero
- flag_v  out  1  signed overflow (ADD/SUB only, else 0)
- flag_n  out  1  alu_out[WIDTH-1]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - out_valid=0, alu_out=0, all flags=0
  - multiply counter and accumulator cleared
  - in_ready=0 while rst_n=0
- Opcodes:
  - 000 ADD: a+b; C=carry-out
  - 001 SUB: a-b; C=1 when no borrow (a>=b unsigned)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: a<<b[CNT_W-1:0]; C=last bit shifted out (0 if shift=0)
  - 110 SHR: logical; C as SHL
  - 111 MUL: unsigned; alu_out = low WIDTH bits of product; C = |high WIDTH bits
- Flags:
  - V is computed for ADD/SUB only.
  - Z and N are derived from the final alu_out.
  - For logical ops C=0.
  - Shift amount ≥ WIDTH gives a result of 0; C = a[0] for SHL when amount==WIDTH, else 0 (SHR symmetric with a[WIDTH-1]).
- Handshake:
  - in_ready = en && state==IDLE && (!out_valid || out_ready).
  - Accept when in_valid && in_ready.
  - Result held stable on alu_out/flags while out_valid && !out_ready.
  - out_valid clears on the out_valid && out_ready edge unless a new result loads on the same edge.
- Latency:
  - Single-cycle ops: accept at edge N → out_valid=1 after edge N. Back-to-back throughput is 1/cycle when out_ready=1.
  - MUL: accept at edge N captures a, b and enters MUL_RUN. One multiplier bit is processed per enabled edge. The result loads and out_valid rises after edge N+WIDTH. in_ready=0 throughout.
- States:
  - IDLE → MUL_RUN on accepted MUL.
  - MUL_RUN → MUL_DONE when count==WIDTH-1.
  - MUL_DONE → IDLE once the result register is free (out_valid==0 or out_ready==1). Result written on that edge.
- en=0 mid-MUL: counter and accumulator freeze; resume on en=1 with no lost iteration.
- Reset mid-MUL: the operation is discarded and no result is produced.
- Opcode values are fully decoded; no illegal encodings.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined:
  - ADD and SUB saturate in two's complement: positive overflow → 0111…1, negative → 1000…0.
  - V still reports that the overflow occurred.
  - C is unchanged from the raw operation.
- Undefined: ADD and SUB wrap modulo 2^WIDTH.
- All other opcodes are identical in both builds.

Decomposition:
- alu_pkg holds:
  - op_e (3-bit enum: OP_ADD…OP_MUL)
  - state_e (IDLE, MUL_RUN, MUL_DONE)
  - flags_t packed struct {z,c,v,n}
- Sub-module alu_mul_iter (parametrised by WIDTH):
  - Ports: start, en, busy, done, product[2*WIDTH].
  - Contains the shift-add datapath and its counter.
- alu_pipe contains the single-cycle ops, the handshake, the FSM and the output register.

Test Plan:
1. WIDTH=8, out_ready=1: a=12h, b=23h, ADD → out_valid 1 cycle later, alu_out=35h, Z=C=V=N=0.
2. a=34h, b=23h, SUB then a=7Fh, b=01h, ADD on consecutive cycles → 11h (C=1), then 80h (V=1, N=1). With ALU_PIPE_SAT_EN, the second result is 7Fh with V=1.
3. a=12h, b=23h, MUL → in_ready low for the duration; after 8 cycles alu_out=76h, C=1; the second operand offered meanwhile is not accepted.
4. Back-pressure: out_ready=0 after an ADD result → alu_out/flags stable and in_ready=0 for 5 cycles; out_ready=1 → handshake completes and the next op is accepted the same cycle.
5. MUL with en=0 held for 3 cycles mid-run → result appears exactly 3 cycles late with the correct value. A separate MUL with rst_n pulsed low mid-run → out_valid stays 0 and all outputs read 0 after reset.
6. SHL a=81h, b=01h → 02h, C=1. SHR a=81h, b=09h → 00h, C=0, Z=1. AND a=F0h, b=0Fh → 00h, Z=1.
